decrement_n: RTL and testbench

- Parametrised, registered multi-bit decrementer/down-counter. It generalises the 1-bit combinational decrement cell to WIDTH bits.
- Adds a variable step, synchronous load, selectable wrap or saturate at zero, a registered borrow pulse and a zero flag.
- Used as the down-counting datapath element in the ALU and as a general countdown/timer primitive.

---
 rtl/decrement_n.sv | 80 ++++++++
 tb/tb_decrement_n.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/decrement_n.sv
// decrement_n: registered WIDTH-bit down-counter with variable step, synchronous
// load, wrap/saturate selection at zero, a one-cycle borrow pulse and a zero flag.
// Optional feature macro: DECREMENT_N_AUTORELOAD_EN. When defined, a wrapping
// underflow reloads the last loaded value instead, turning the block into a
// periodic timer.
module decrement_n #(
   parameter int unsigned           WIDTH     = 8,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic [WIDTH-1:0] step,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] count,
   output logic             borrow,
   output logic             zero
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH:0]   diff;
   logic             underflow;
   logic [WIDTH-1:0] wrap_val;

   // One extra bit so the MSB of the difference is the underflow flag.
   assign diff      = {1'b0, count_q} - {1'b0, step};
   assign underflow = diff[WIDTH];

`ifdef DECREMENT_N_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q;

   // Reload register tracks the most recent load value.
   always_ff @(posedge clk) begin
      if (rst) begin
         reload_q <= RESET_VAL;
      end else if (load) begin
         reload_q <= load_val;
      end
   end

   assign wrap_val = reload_q;
`else
   assign wrap_val = diff[WIDTH-1:0];
`endif

   // Next-state selection: load beats decrement beats hold.
   always_comb begin
      count_d  = count_q;
      borrow_d = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         if (underflow) begin
            borrow_d = 1'b1;
            count_d  = sat_mode ? '0 : wrap_val;
         end else begin
            count_d = diff[WIDTH-1:0];
         end
      end
   end

   // State register; reset overrides every request.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= RESET_VAL;
         borrow_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         borrow_q <= borrow_d;
      end
   end

   assign count  = count_q;
   assign borrow = borrow_q;
   assign zero   = (count_q == '0);

endmodule

// File: tb/tb_decrement_n.sv
// Directed self-checking bench for decrement_n (WIDTH=8 plus a WIDTH=1 instance).
// Expected values for the wrap-to-reload case follow DECREMENT_N_AUTORELOAD_EN.
module tb_decrement_n;

   logic       clk = 1'b0;
   logic       rst, load, en, sat_mode;
   logic [7:0] load_val, step;
   logic [7:0] count;
   logic       borrow, zero;

   logic       load1, en1;
   logic [0:0] load_val1, step1, count1;
   logic       borrow1, zero1;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   decrement_n #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
      .step(step), .sat_mode(sat_mode), .count(count), .borrow(borrow), .zero(zero)
   );

   decrement_n #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
      .clk(clk), .rst(rst), .load(load1), .load_val(load_val1), .en(en1),
      .step(step1), .sat_mode(1'b0), .count(count1), .borrow(borrow1), .zero(zero1)
   );

   // Drive one cycle of stimulus on the 8-bit instance, then sample 1 time unit after the edge.
   task automatic cyc(input logic r, input logic l, input logic [7:0] lv, input logic e,
                      input logic [7:0] s, input logic sm);
      rst = r; load = l; load_val = lv; en = e; step = s; sat_mode = sm;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      cyc(1'b1, 1'b1, 8'h55, 1'b1, 8'h01, 1'b0);
      tests_run++;
      if (count !== 8'h00) begin
         tests_failed++; $display("FAIL reset_count: got %h want 00", count);
      end
      tests_run++;
      if (zero !== 1'b1) begin
         tests_failed++; $display("FAIL reset_zero: got %b want 1", zero);
      end
      tests_run++;
      if (borrow !== 1'b0) begin
         tests_failed++; $display("FAIL reset_borrow: got %b want 0", borrow);
      end
   endtask

   task automatic test_countdown;
      logic [7:0] exp;
      cyc(1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0);
      tests_run++;
      if (count !== 8'h05 || zero !== 1'b0) begin
         tests_failed++; $display("FAIL load5: got %h/%b want 05/0", count, zero);
      end
      for (int i = 0; i < 5; i++) begin
         exp = 8'(4 - i);
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
         tests_run++;
         if (count !== exp || borrow !== 1'b0) begin
            tests_failed++;
            $display("FAIL countdown[%0d]: got %h/%b want %h/0", i, count, borrow, exp);
         end
      end
      tests_run++;
      if (zero !== 1'b1) begin
         tests_failed++; $display("FAIL countdown_zero: got %b want 1", zero);
      end
   endtask

   task automatic test_wrap;
      cyc(1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0);
`ifdef DECREMENT_N_AUTORELOAD_EN
      tests_run++;
      if (count !== 8'h03 || borrow !== 1'b1) begin
         tests_failed++; $display("FAIL wrap: got %h/%b want 03/1", count, borrow);
      end
`else
      tests_run++;
      if (count !== 8'hFE || borrow !== 1'b1) begin
         tests_failed++; $display("FAIL wrap: got %h/%b want fe/1", count, borrow);
      end
`endif
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0);
      tests_run++;
      if (borrow !== 1'b0) begin
         tests_failed++; $display("FAIL wrap_pulse: borrow got %b want 0", borrow);
      end
   endtask

   task automatic test_saturate;
      cyc(1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1);
      tests_run++;
      if (count !== 8'h00 || borrow !== 1'b1 || zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL sat: got %h/%b/%b want 00/1/1", count, borrow, zero);
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1);
      tests_run++;
      if (count !== 8'h00 || borrow !== 1'b1) begin
         tests_failed++; $display("FAIL sat_again: got %h/%b want 00/1", count, borrow);
      end
   endtask

   task automatic test_load_priority;
      cyc(1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'h20, 1'b1, 8'h01, 1'b0);
      tests_run++;
      if (count !== 8'h20 || borrow !== 1'b0) begin
         tests_failed++; $display("FAIL load_over_en: got %h/%b want 20/0", count, borrow);
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      tests_run++;
      if (count !== 8'h20 || borrow !== 1'b0) begin
         tests_failed++; $display("FAIL step0: got %h/%b want 20/0", count, borrow);
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0);
      tests_run++;
      if (count !== 8'h00 || borrow !== 1'b0 || zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL step_eq: got %h/%b/%b want 00/0/1", count, borrow, zero);
      end
   endtask

   task automatic test_back_to_back;
      cyc(1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
      tests_run++;
      if (count !== 8'h01 || borrow !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_0: got %h/%b want 01/0", count, borrow);
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
      tests_run++;
      if (count !== 8'h00 || borrow !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_1: got %h/%b want 00/0", count, borrow);
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
`ifdef DECREMENT_N_AUTORELOAD_EN
      tests_run++;
      if (count !== 8'h02 || borrow !== 1'b1) begin
         tests_failed++; $display("FAIL b2b_2: got %h/%b want 02/1", count, borrow);
      end
`else
      tests_run++;
      if (count !== 8'hFF || borrow !== 1'b1) begin
         tests_failed++; $display("FAIL b2b_2: got %h/%b want ff/1", count, borrow);
      end
`endif
   endtask

   task automatic test_mid_reset;
      cyc(1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1);
      // borrow is high here; reset with en pending must clear it.
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0);
      tests_run++;
      if (count !== 8'h00 || borrow !== 1'b0) begin
         tests_failed++; $display("FAIL mid_reset: got %h/%b want 00/0", count, borrow);
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_width1;
      load1 = 1'b1; load_val1 = 1'b1; en1 = 1'b0; step1 = 1'b1;
      @(posedge clk); #1;
      load1 = 1'b0; en1 = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (count1 !== 1'b0 || borrow1 !== 1'b0) begin
         tests_failed++; $display("FAIL w1_1to0: got %b/%b want 0/0", count1, borrow1);
      end
      @(posedge clk); #1;
      tests_run++;
      if (count1 !== 1'b1 || borrow1 !== 1'b1) begin
         tests_failed++; $display("FAIL w1_0to1: got %b/%b want 1/1", count1, borrow1);
      end
      en1 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; step = '0; sat_mode = 1'b0;
      load1 = 1'b0; load_val1 = '0; en1 = 1'b0; step1 = '0;
      test_reset;
      test_countdown;
      test_wrap;
      test_saturate;
      test_load_priority;
      test_back_to_back;
      test_mid_reset;
      test_width1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
